// File: rtl/cache_pkg.sv
// Shared cache geometry and miss-controller state encoding.
// Used by cache_4way_64KB and its miss handler so both agree on line layout.
// Byte address layout: [ADDR_W-1:OFS] line tag/index, [OFS-1:2] word, [1:0] byte.
package cache_pkg;

    localparam int LINE_WORDS = 4;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int IDX_W      = $clog2(LINE_WORDS);
    localparam int OFS        = IDX_W + 2;

    // Miss controller FSM encoding, kept as plain constants for older tools.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/cache_miss_ctrl.sv
// Purpose: serialise one cache miss: dirty victim write-back, then critical-word-first line fetch.
// Latency: clean miss with 0-wait memory gives fill beats 2..LINE_WORDS+1 cycles after the request.
// Backpressure: memory beats hold stable until iMemAck; new misses are dropped while oBusy=1.
module cache_miss_ctrl #(
    parameter int   LINE_WORDS = cache_pkg::LINE_WORDS,
    parameter int   DATA_W     = cache_pkg::DATA_W,
    parameter int   ADDR_W     = cache_pkg::ADDR_W,
    localparam int  CNT_W      = $clog2(LINE_WORDS),
    localparam int  OFS_W      = CNT_W + 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         iMissReq,
    input  logic [ADDR_W-1:0]            iMissAddr,
    input  logic                         iEvictDirty,
    input  logic [ADDR_W-1:0]            iEvictAddr,
    input  logic [LINE_WORDS*DATA_W-1:0] iEvictLine,
    output logic                         oBusy,
    output logic                         oFillValid,
    output logic [CNT_W-1:0]             oFillIdx,
    output logic [DATA_W-1:0]            oFillData,
    output logic                         oFillDone,
    output logic                         oMemReq,
    output logic                         oMemWe,
    output logic [ADDR_W-1:0]            oMemAddr,
    output logic [DATA_W-1:0]            oMemWData,
    input  logic                         iMemAck,
    input  logic [DATA_W-1:0]            iMemRData
);

    import cache_pkg::*;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

    logic [1:0]                   state;
    logic [CNT_W-1:0]             cnt;       // word index of the beat on the bus (wraps)
    logic [CNT_W-1:0]             beats;     // read acks taken so far in this miss
    logic [ADDR_W-1:0]            missAddr;
    logic [ADDR_W-1:0]            evictAddr;
    logic [LINE_WORDS*DATA_W-1:0] evictLine;

    // FSM, beat counters, request latch and registered fill beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            beats      <= '0;
            missAddr   <= '0;
            evictAddr  <= '0;
            evictLine  <= '0;
            oFillValid <= 1'b0;
            oFillDone  <= 1'b0;
            oFillIdx   <= '0;
            oFillData  <= '0;
        end else begin
            oFillValid <= 1'b0;
            oFillDone  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iMissReq) begin
                        missAddr  <= iMissAddr;
                        evictAddr <= iEvictAddr;
                        evictLine <= iEvictLine;
                        beats     <= '0;
                        if (iEvictDirty) begin
                            state <= ST_WB;
                            cnt   <= '0;
                        end else begin
                            state <= ST_RD;
                            cnt   <= iMissAddr[OFS_W-1:2];
                        end
                    end
                end
                ST_WB: begin
                    if (iMemAck) begin
                        if (cnt == LAST_IDX) begin
                            // Straight into the fetch, starting at the critical word.
                            state <= ST_RD;
                            cnt   <= missAddr[OFS_W-1:2];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (iMemAck) begin
                        oFillValid <= 1'b1;
                        oFillIdx   <= cnt;
                        oFillData  <= iMemRData;
                        cnt        <= cnt + 1'b1;   // power-of-2 width gives the line wrap
                        beats      <= beats + 1'b1;
                        if (beats == LAST_IDX) begin
                            state     <= ST_DONE;
                            oFillDone <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs decode from state and counter, so they only move on ack or state change.
    always_comb begin
        oBusy     = (state != ST_IDLE);
        oMemReq   = 1'b0;
        oMemWe    = 1'b0;
        oMemAddr  = '0;
        oMemWData = '0;
        if (state == ST_WB) begin
            oMemReq   = 1'b1;
            oMemWe    = 1'b1;
            oMemAddr  = {evictAddr[ADDR_W-1:OFS_W], cnt, 2'b00};
            oMemWData = evictLine[cnt*DATA_W +: DATA_W];
        end else if (state == ST_RD) begin
            oMemReq  = 1'b1;
            oMemAddr = {missAddr[ADDR_W-1:OFS_W], cnt, 2'b00};
        end
    end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Miss handler downstream of cache_4way_64KB, between the cache and main memory.
- On a cache miss, writes back the dirty victim line word by word, then fetches the missing line critical-word-first.
- Returns each fetched word to the cache's data RAM as a fill beat.
- Serialises one miss at a time over a simple req/ack single-word memory bus.

Parameters:
LINE_WORDS, 4, words per cache line; power of 2, >= 2.
DATA_W, 32, word width in bits.
ADDR_W, 32, byte address width.

Ports:
clk  input  1  system clock, all state on posedge.
resetn  input  1  asynchronous active-low reset.
iMissReq  input  1  one-cycle miss request; sampled only when oBusy=0.
iMissAddr  input  ADDR_W  byte address of the missing word; bits [1:0] ignored.
iEvictDirty  input  1  victim line is dirty and needs write-back.
iEvictAddr  input  ADDR_W  base address of the victim line; offset bits ignored.
iEvictLine  input  LINE_WORDS*DATA_W  victim data; word i is at [i*DATA_W +: DATA_W].
oBusy  output  1  miss in progress.
oFillValid  output  1  fill beat valid.
oFillIdx  output  log2(LINE_WORDS)  word index within the line for this beat.
oFillData  output  DATA_W  fill word.
oFillDone  output  1  asserted together with the last fill beat.
oMemReq  output  1  memory request.
oMemWe  output  1  1 = write, 0 = read.
oMemAddr  output  ADDR_W  word-aligned byte address.
oMemWData  output  DATA_W  write data.
iMemAck  input  1  memory accepts the beat; for reads, iMemRData is valid in the same cycle.
iMemRData  input  DATA_W  read data.

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; all outputs 0; beat counter 0; latched request cleared. Reset mid-operation aborts the miss: no further fill beats, no oFillDone.
- States: IDLE, WB, RD, DONE.
- IDLE:
  - On iMissReq=1, latch iMissAddr, iEvictAddr and iEvictLine, and set oBusy=1 the next cycle.
  - Next state is WB if iEvictDirty=1, else RD.
  - The beat counter loads 0 for WB, or iMissAddr[OFS-1:2] for RD, where OFS = log2(LINE_WORDS)+2.
- WB:
  - oMemReq=1, oMemWe=1.
  - oMemAddr = {evictAddr[ADDR_W-1:OFS], cnt, 2'b00}; oMemWData = latched word cnt.
  - Outputs stay stable until iMemAck.
  - On ack: cnt+1. After the ack of word LINE_WORDS-1, go to RD with cnt = critical index, and present the first read beat in the next cycle (no idle gap).
- RD:
  - oMemReq=1, oMemWe=0; oMemAddr = {missAddr[ADDR_W-1:OFS], cnt, 2'b00}.
  - On ack: the next cycle drives oFillValid=1, oFillIdx=cnt (value at ack), oFillData=iMemRData (registered).
  - cnt increments modulo LINE_WORDS, so the beat order wraps, e.g. start 2 gives 2,3,0,1.
  - After LINE_WORDS acks, go to DONE with oMemReq=0 in that cycle.
- DONE: the cycle carrying the last fill beat, with oFillDone=1. Next cycle: IDLE, oBusy=0.
- oMemReq may stay high back-to-back across consecutive acks. oMemWe, oMemAddr and oMemWData change only after an ack or on a state change.
- Ack latency is unbounded; the controller waits indefinitely.
- iMemAck while oMemReq=0 is ignored.
- iMissReq while oBusy=1 is ignored and not queued. This includes the DONE cycle.
- oFillValid and oFillDone are single-cycle pulses. Outside fill beats, oFillData/oFillIdx hold their last value.
- Minimum latency, clean miss with ack every cycle: request at cycle T; read beats present T+1..T+LINE_WORDS; fill beats T+2..T+LINE_WORDS+1; oBusy low at T+LINE_WORDS+2.

Decomposition:
- Package cache_pkg: state encoding (IDLE/WB/RD/DONE), LINE_WORDS, DATA_W, ADDR_W, OFS, index width. Shared with cache_4way_64KB.
- No sub-module. The FSM and the wrap-around beat counter are inline; the block is about 200 lines.

Test Plan:
- Clean miss: iMissAddr=32'hFDEF_1008, iEvictDirty=0; memory returns addr^32'hA5A5_0000 with 0-cycle ack.
  → Reads at ...1008, ...100C, ...1000, ...1004. Fill idx 2,3,0,1 with matching data; oFillDone on idx 1; oBusy low 6 cycles after the request.
- Dirty miss: iEvictDirty=1, iEvictAddr=32'h0000_2000, iEvictLine={32'h4,32'h3,32'h2,32'h1}, iMissAddr=32'hFDEF_1000.
  → Writes 2000=1, 2004=2, 2008=3, 200C=4, then reads 1000..100C, then fill beats idx 0..3.
- Random ack stalls of 0–5 cycles.
  → Request outputs stay stable while unacked; exactly 4 fill beats; correct data and order.
- iMissReq pulsed during WB, RD and DONE.
  → Ignored: no extra memory traffic. A new request in the first cycle oBusy=0 is accepted.
- resetn low during RD after 2 acks.
  → All outputs 0 immediately; no oFillDone. A subsequent miss completes normally.
- Offset wrap at last word: iMissAddr=32'h0000_000C, clean miss.
  → Fill order 3,0,1,2; addresses 000C, 0000, 0004, 0008.
